sr_latch_driver: RTL
====================

Name: sr_latch_driver

Overview:
- Upstream command stage for the gated SR latch: turns two raw, bouncy pushbuttons (set, reset) into clean, mutually exclusive En/S/R drive sequences for the latch's En, S and R inputs.
- Per button: 2-flop synchronizer, debouncer, press-edge detector.
- A shared arbiter FSM issues one fixed-length enable window per accepted press.
- Also exports a shadow copy of the latch state that the bench compares against the latch's Q.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to change a debounced level; legal range 2..65535.
- PULSE_CYCLES, 2, cycles En is held high per command; legal range 1..255.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- nRst  input  1  reset; synchronous, active-low.
- SetBtn  input  1  raw asynchronous set pushbutton, active-high.
- RstBtn  input  1  raw asynchronous reset pushbutton, active-high.
- En  output  1  latch enable, registered.
- S  output  1  latch set input, registered.
- R  output  1  latch reset input, registered.
- Busy  output  1  high while the FSM is in DRIVE_S, DRIVE_R or GAP.
- LatchState  output  1  shadow of the expected latch Q.

Behaviour:
- Reset (nRst=0 at a rising edge):
  - En, S, R, Busy, LatchState = 0.
  - Synchronizers, debounced levels, edge registers and pending flags = 0; counters = 0; FSM = IDLE.
  - Reset mid-DRIVE aborts the window: En/S/R drop to 0 at that same edge.
- Synchronizer: 2 flops per button. Output sync_x is the button level delayed 2 edges.
- Debouncer (per button):
  - If sync_x equals debounced level deb_x, the counter clears to 0.
  - Otherwise the counter increments.
  - At the edge where the counter equals DEBOUNCE_CYCLES-1 and sync_x still differs, deb_x toggles and the counter clears.
  - Net effect: deb_x changes only after DEBOUNCE_CYCLES consecutive differing samples. Any glitch shorter than that is rejected.
- Edge detect: pend_x is set at the edge after deb_x goes 0->1. A release (1->0) generates nothing.
- Pending flags:
  - One-deep per button.
  - A press arriving while pend_x is already set is dropped.
  - pend_x clears at the edge the FSM leaves IDLE for that command.
- FSM states:
  - IDLE:
    - pend_r=1 -> DRIVE_R; R wins if both are pending.
    - else pend_s=1 -> DRIVE_S.
    - else stay in IDLE.
  - DRIVE_S: En=1, S=1, R=0 for exactly PULSE_CYCLES cycles, then -> GAP.
  - DRIVE_R: En=1, S=0, R=1 for exactly PULSE_CYCLES cycles, then -> GAP.
  - GAP: En=S=R=0 for exactly 1 cycle, then -> IDLE.
  - IDLE: En=S=R=0.
- Outputs are registered from the next state, so En rises at the same edge the FSM enters a DRIVE state.
- Latency: deb_x rises at edge k -> pend_x=1 at k+1 -> En=1 at k+2 (when the FSM is IDLE at k+1).
- Invariants (checked every cycle):
  - S&R = 0.
  - S|R implies En.
  - En=0 for at least 1 cycle between consecutive commands.
- Presses during DRIVE/GAP are kept in pend_x and served from IDLE. A same-type re-press is re-issued.
- LatchState is updated at the edge leaving DRIVE_S (set to 1) or DRIVE_R (cleared to 0).
- Pulse counter width: 8 bits; wraps never reached (legal PULSE_CYCLES ≤ 255).

Test Plan (bench with DEBOUNCE_CYCLES=4, PULSE_CYCLES=2):
- Reset check: nRst=0 for 3 cycles with both buttons at 1 -> En=S=R=Busy=LatchState=0 throughout; no command issued after release of nRst until a fresh 0->1 press.
- Clean set: SetBtn held 1 -> En=S=1 for exactly 2 cycles, beginning 2+4+2 edges after the first sampled 1; then GAP; then LatchState=1; Busy high for 3 cycles.
- Bounce rejection: SetBtn toggling 1,0,1,0 each cycle for 12 cycles, then 0 -> no En pulse; LatchState unchanged.
- Simultaneous press: both buttons rise on the same cycle -> R window first (R=1, S=0), then 1-cycle gap, then S window. Final LatchState=1; S&R never 1.
- Queued press: RstBtn pressed while a DRIVE_S window is active -> R window starts 1 cycle after GAP; LatchState goes 1 -> 0.
- Reset mid-DRIVE: assert nRst=0 during the first En=1 cycle -> En/S/R=0 at that edge; pending cleared; LatchState=0.

Source files
------------

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Command stage in front of a gated SR latch. Two raw, bouncy pushbuttons
//   are each synchronized, debounced and edge-detected. A small arbiter FSM
//   then turns every accepted press into one fixed-length En window with S
//   or R, separated by at least one idle cycle. A shadow of the latch Q is
//   kept for comparison against the real latch.
//
// Ports
//   Clk        in   clock, rising edge
//   nRst       in   synchronous active-low reset
//   SetBtn     in   raw set pushbutton (asynchronous, active-high)
//   RstBtn     in   raw reset pushbutton (asynchronous, active-high)
//   En         out  latch enable (registered)
//   S          out  latch set input (registered)
//   R          out  latch reset input (registered)
//   Busy       out  high while in DRIVE_S, DRIVE_R or GAP
//   LatchState out  expected latch Q

// sr_btn_cond
//   One button channel: 2-flop synchronizer, counter debouncer and a
//   press (0->1) edge detector.
//
// Ports
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   btn    in   raw button level
//   press  out  one-cycle pulse in the cycle after the debounced level rises
module sr_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_q <= deb;
            // Any sample agreeing with the debounced level restarts the run,
            // so only an unbroken run of differing samples flips deb.
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Release (1->0) deliberately produces nothing.
    assign press = deb & ~deb_q;
endmodule

module sr_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 2,
    parameter int CNT_W           = 16
) (
    input  logic Clk,
    input  logic nRst,
    input  logic SetBtn,
    input  logic RstBtn,
    output logic En,
    output logic S,
    output logic R,
    output logic Busy,
    output logic LatchState
);
    localparam int          NUM_BTN    = 2;   // index 0 = set, 1 = reset
    localparam logic [7:0]  PULSE_LAST = 8'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] press;
    logic               pend_s;
    logic               pend_r;
    state_t             state;
    state_t             state_nxt;
    logic [7:0]         pcnt;
    logic [7:0]         pcnt_nxt;
    logic               take_s;
    logic               take_r;

    assign btn = {RstBtn, SetBtn};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            sr_btn_cond #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_cond (
                .clk  (Clk),
                .rst_n(nRst),
                .btn  (btn[g]),
                .press(press[g])
            );
        end
    endgenerate

    assign take_s = (state == IDLE) && (state_nxt == DRIVE_S);
    assign take_r = (state == IDLE) && (state_nxt == DRIVE_R);

    // One-deep pending flags. A press landing on an already-set flag is
    // simply absorbed; a flag clears only when its command is launched.
    always_ff @(posedge Clk) begin
        if (!nRst) begin
            pend_s <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            if (take_s)        pend_s <= 1'b0;
            else if (press[0]) pend_s <= 1'b1;
            if (take_r)        pend_r <= 1'b0;
            else if (press[1]) pend_r <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        case (state)
            IDLE: begin
                pcnt_nxt = '0;
                // Reset wins a tie so a double press leaves the latch set
                // last, matching the order the operator most likely meant.
                if (pend_r)      state_nxt = DRIVE_R;
                else if (pend_s) state_nxt = DRIVE_S;
            end
            DRIVE_S, DRIVE_R: begin
                if (pcnt == PULSE_LAST) begin
                    state_nxt = GAP;
                    pcnt_nxt  = '0;
                end else begin
                    pcnt_nxt = pcnt + 8'd1;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so En rises on the same
    // edge the FSM enters a DRIVE state.
    always_ff @(posedge Clk) begin
        if (!nRst) begin
            state      <= IDLE;
            pcnt       <= '0;
            En         <= 1'b0;
            S          <= 1'b0;
            R          <= 1'b0;
            Busy       <= 1'b0;
            LatchState <= 1'b0;
        end else begin
            state <= state_nxt;
            pcnt  <= pcnt_nxt;
            En    <= (state_nxt == DRIVE_S) || (state_nxt == DRIVE_R);
            S     <= (state_nxt == DRIVE_S);
            R     <= (state_nxt == DRIVE_R);
            Busy  <= (state_nxt != IDLE);
            if (state == DRIVE_S && state_nxt == GAP) LatchState <= 1'b1;
            if (state == DRIVE_R && state_nxt == GAP) LatchState <= 1'b0;
        end
    end
endmodule
